// File: rtl/video_pkg.sv
// Shared types, register offsets and colour constants for the video pattern generator.
package video_pkg;

    typedef logic [23:0] rgb_t;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_GRAD  = 2'd3
    } mode_e;

    localparam logic [31:0] REG_CTRL_OFS  = 32'h0000_0000;
    localparam logic [31:0] REG_SOLID_OFS = 32'h0000_0004;

    localparam rgb_t RGB_BLACK = 24'h00_00_00;
    localparam rgb_t RGB_WHITE = 24'hFF_FF_FF;

    // Colour-bar table, left to right across the active line.
    function automatic rgb_t bar_color(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = 24'hFF_FF_FF;
            3'd1:    c = 24'hFF_FF_00;
            3'd2:    c = 24'h00_FF_FF;
            3'd3:    c = 24'h00_FF_00;
            3'd4:    c = 24'hFF_00_FF;
            3'd5:    c = 24'hFF_00_00;
            3'd6:    c = 24'h00_00_FF;
            3'd7:    c = 24'h00_00_00;
            default: c = 24'h00_00_00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/video_timing_core.sv
// Pixel-rate divider, horizontal/vertical raster counters, raw timing flags and frame-start pulse.
module video_timing_core #(
    parameter int H_ACTIVE = 320,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 4,
    parameter int H_BP     = 60,
    parameter int V_ACTIVE = 240,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 10,
    parameter int CLK_DIV  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_en_o,
    output logic [9:0] h_cnt_o,
    output logic [9:0] v_cnt_o,
    output logic       de_o,
    output logic       hs_o,
    output logic       vs_o,
    output logic       frame_start_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [HW-1:0]    H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]    H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0]    H_HS_POS = HW'(H_ACTIVE + H_FP);
    localparam logic [VW-1:0]    V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]    V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0]    V_VS_POS = VW'(V_ACTIVE + V_FP);

    if (HW > 10 || VW > 10) begin : g_width_err
        $error("video_timing_core: raster counter wider than 10 bits");
    end

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [HW-1:0]    h_cnt_q, h_cnt_d;
    logic [VW-1:0]    v_cnt_q, v_cnt_d;
    logic             frame_start_q, frame_start_d;
    logic             pix_en_s, h_wrap_s, v_wrap_s;

    // Divider and raster counter next-state.
    always_comb begin
        pix_en_s  = (div_cnt_q == DIV_LAST);
        h_wrap_s  = (h_cnt_q == H_LAST);
        v_wrap_s  = (v_cnt_q == V_LAST);
        div_cnt_d = div_cnt_q;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        if (pix_en_s) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
        if (!pix_en_s) begin
            h_cnt_d = h_cnt_q;
            v_cnt_d = v_cnt_q;
        end else if (h_wrap_s) begin
            h_cnt_d = '0;
            if (v_wrap_s) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + VW'(1);
            end
        end else begin
            h_cnt_d = h_cnt_q + HW'(1);
            v_cnt_d = v_cnt_q;
        end
        frame_start_d = pix_en_s && h_wrap_s && v_wrap_s;
    end

    // Counter and frame-start state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q     <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_en_o      = pix_en_s;
    assign h_cnt_o       = 10'(h_cnt_q);
    assign v_cnt_o       = 10'(v_cnt_q);
    assign de_o          = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign hs_o          = (h_cnt_q == H_HS_POS);
    assign vs_o          = (h_cnt_q == H_HS_POS) && (v_cnt_q == V_VS_POS);
    assign frame_start_o = frame_start_q;

endmodule

// File: rtl/video_pattern_gen.sv
// Video timing and test-pattern generator: config registers, frame-boundary load and pattern mux
// around the raster timing core.
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int          H_ACTIVE = 320,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 4,
    parameter int          H_BP     = 60,
    parameter int          V_ACTIVE = 240,
    parameter int          V_FP     = 4,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 10,
    parameter int          CLK_DIV  = 2,
    parameter logic [31:0] CFG_BASE = 32'h0000_0000
) (
    input  logic        clk_core_12288,
    input  logic        reset_n,
    input  logic [31:0] bridge_addr,
    input  logic        bridge_wr,
    input  logic [31:0] bridge_wr_data,
    output logic [23:0] video_rgb,
    output logic        video_de,
    output logic        video_hs,
    output logic        video_vs,
    output logic        video_skip,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        frame_start
);

    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    logic       pix_en_s, de_s, hs_s, vs_s;
    logic [9:0] h_cnt_s, v_cnt_s;

    video_timing_core #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CLK_DIV (CLK_DIV)
    ) u_timing (
        .clk          (clk_core_12288),
        .rst_n        (reset_n),
        .pix_en_o     (pix_en_s),
        .h_cnt_o      (h_cnt_s),
        .v_cnt_o      (v_cnt_s),
        .de_o         (de_s),
        .hs_o         (hs_s),
        .vs_o         (vs_s),
        .frame_start_o(frame_start)
    );

    logic  shadow_en_q, shadow_en_d, live_en_q, live_en_d;
    mode_e shadow_mode_q, shadow_mode_d, live_mode_q, live_mode_d;
    rgb_t  shadow_solid_q, shadow_solid_d, live_solid_q, live_solid_d;
    logic  wr_ctrl_s, wr_solid_s, boundary_s;
    rgb_t  pattern_s;
    logic [9:0] bar_idx_s;
    logic  unused_bits_s;

    // Register decode, shadow writes and the frame-boundary live load.
    always_comb begin
        wr_ctrl_s  = bridge_wr && (bridge_addr == (CFG_BASE + REG_CTRL_OFS));
        wr_solid_s = bridge_wr && (bridge_addr == (CFG_BASE + REG_SOLID_OFS));
        boundary_s = pix_en_s && (h_cnt_s == 10'd0) && (v_cnt_s == 10'd0);
        if (wr_ctrl_s) begin
            shadow_en_d   = bridge_wr_data[0];
            shadow_mode_d = mode_e'(bridge_wr_data[2:1]);
        end else begin
            shadow_en_d   = shadow_en_q;
            shadow_mode_d = shadow_mode_q;
        end
        if (wr_solid_s) begin
            shadow_solid_d = bridge_wr_data[23:0];
        end else begin
            shadow_solid_d = shadow_solid_q;
        end
        // The boundary pixel itself already uses the freshly loaded config.
        if (boundary_s) begin
            live_en_d    = shadow_en_q;
            live_mode_d  = shadow_mode_q;
            live_solid_d = shadow_solid_q;
        end else begin
            live_en_d    = live_en_q;
            live_mode_d  = live_mode_q;
            live_solid_d = live_solid_q;
        end
    end

    // Pattern colour for the pixel at the current counter position.
    always_comb begin
        bar_idx_s = h_cnt_s / 10'(BAR_W);
        pattern_s = RGB_BLACK;
        case (live_mode_d)
            MODE_SOLID: pattern_s = live_solid_d;
            MODE_BARS: begin
                if (bar_idx_s < 10'd8) begin
                    pattern_s = bar_color(bar_idx_s[2:0]);
                end else begin
                    pattern_s = RGB_BLACK;
                end
            end
            MODE_CHECK: begin
                if (h_cnt_s[3] ^ v_cnt_s[3]) begin
                    pattern_s = RGB_WHITE;
                end else begin
                    pattern_s = RGB_BLACK;
                end
            end
            MODE_GRAD: pattern_s = {h_cnt_s[7:0], v_cnt_s[7:0], 8'h80};
            default:   pattern_s = RGB_BLACK;
        endcase
    end

    // Config register state.
    always_ff @(posedge clk_core_12288 or negedge reset_n) begin
        if (!reset_n) begin
            shadow_en_q    <= 1'b1;
            shadow_mode_q  <= MODE_BARS;
            shadow_solid_q <= 24'h00_00_00;
            live_en_q      <= 1'b1;
            live_mode_q    <= MODE_BARS;
            live_solid_q   <= 24'h00_00_00;
        end else begin
            shadow_en_q    <= shadow_en_d;
            shadow_mode_q  <= shadow_mode_d;
            shadow_solid_q <= shadow_solid_d;
            live_en_q      <= live_en_d;
            live_mode_q    <= live_mode_d;
            live_solid_q   <= live_solid_d;
        end
    end

    logic [23:0] rgb_q, rgb_d;
    logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d;
    logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;

    // Output stage: captures one pixel per pix_en, blanked when disabled.
    always_comb begin
        if (pix_en_s) begin
            de_d    = live_en_d && de_s;
            hs_d    = live_en_d && hs_s;
            vs_d    = live_en_d && vs_s;
            rgb_d   = (live_en_d && de_s) ? pattern_s : RGB_BLACK;
            pix_x_d = h_cnt_s;
            pix_y_d = v_cnt_s;
        end else begin
            de_d    = de_q;
            hs_d    = hs_q;
            vs_d    = vs_q;
            rgb_d   = rgb_q;
            pix_x_d = pix_x_q;
            pix_y_d = pix_y_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk_core_12288 or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q   <= 24'h00_00_00;
            de_q    <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            pix_x_q <= 10'd0;
            pix_y_q <= 10'd0;
        end else begin
            rgb_q   <= rgb_d;
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            pix_x_q <= pix_x_d;
            pix_y_q <= pix_y_d;
        end
    end

    assign unused_bits_s = ^{bridge_wr_data[31:24], v_cnt_s[9:8]};

    assign video_rgb  = rgb_q;
    assign video_de   = de_q;
    assign video_hs   = hs_q;
    assign video_vs   = vs_q;
    assign video_skip = 1'b0;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen on a reduced raster, plus a CLK_DIV=1 instance.
`timescale 1ns/1ps
module tb_video_pattern_gen;

    localparam int HA = 20, HFP = 2, HSW = 2, HBP = 4;
    localparam int VA = 10, VFP = 1, VSW = 1, VBP = 2;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam int CLKD = 2;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [31:0] bridge_addr = 32'h0;
    logic        bridge_wr = 1'b0;
    logic [31:0] bridge_wr_data = 32'h0;

    logic [23:0] video_rgb;
    logic video_de, video_hs, video_vs, video_skip, frame_start;
    logic [9:0] pix_x, pix_y;
    logic [23:0] u1_rgb;
    logic u1_de, u1_hs, u1_vs, u1_skip, u1_fs;
    logic [9:0] u1_x, u1_y;

    always #5 clk = ~clk;

    video_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .CLK_DIV(CLKD), .CFG_BASE(BASE)
    ) dut (
        .clk_core_12288(clk), .reset_n(reset_n),
        .bridge_addr(bridge_addr), .bridge_wr(bridge_wr), .bridge_wr_data(bridge_wr_data),
        .video_rgb(video_rgb), .video_de(video_de), .video_hs(video_hs), .video_vs(video_vs),
        .video_skip(video_skip), .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start)
    );

    video_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .CLK_DIV(1), .CFG_BASE(BASE)
    ) dut1 (
        .clk_core_12288(clk), .reset_n(reset_n),
        .bridge_addr(bridge_addr), .bridge_wr(bridge_wr), .bridge_wr_data(bridge_wr_data),
        .video_rgb(u1_rgb), .video_de(u1_de), .video_hs(u1_hs), .video_vs(u1_vs),
        .video_skip(u1_skip), .pix_x(u1_x), .pix_y(u1_y), .frame_start(u1_fs)
    );

    typedef struct packed {
        logic [23:0] rgb;
        logic de, hs, vs, fs;
        logic [9:0] x, y;
    } obs_t;

    typedef struct packed {
        obs_t o;
        logic [1:0] mode;
    } sb_t;

    sb_t sb_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state.
    int m_h, m_v;
    logic sh_en, lv_en, fr_en;
    logic [1:0] sh_mode, lv_mode;
    logic [23:0] sh_solid, lv_solid;
    int n_de, n_hs, n_vs;
    int cyc = 0;
    int last_fs;
    bit fs_seen;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] bar_ref(input int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic obs_t model_pix(input int h, input int v, input logic en,
                                       input logic [1:0] mode, input logic [23:0] solid);
        obs_t o;
        logic [9:0] hx, vy;
        logic de;
        hx = 10'(h);
        vy = 10'(v);
        o = '0;
        o.x = hx;
        o.y = vy;
        o.fs = (h == HT - 1) && (v == VT - 1);
        de = (h < HA) && (v < VA);
        if (en) begin
            o.de = de;
            o.hs = (h == HA + HFP);
            o.vs = (h == HA + HFP) && (v == VA + VFP);
            if (de) begin
                case (mode)
                    2'd0: o.rgb = solid;
                    2'd1: o.rgb = bar_ref(h / (HA / 8));
                    2'd2: o.rgb = (hx[3] ^ vy[3]) ? 24'hFFFFFF : 24'h000000;
                    default: o.rgb = {hx[7:0], vy[7:0], 8'h80};
                endcase
            end
        end
        return o;
    endfunction

    function automatic obs_t dut_obs();
        return {video_rgb, video_de, video_hs, video_vs, frame_start, pix_x, pix_y};
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d);
        if (a == BASE) begin
            sh_en = d[0];
            sh_mode = d[2:1];
        end else if (a == BASE + 32'd4) begin
            sh_solid = d[23:0];
        end
    endtask

    task automatic model_reset();
        m_h = 0; m_v = 0;
        sh_en = 1'b1; lv_en = 1'b1; fr_en = 1'b1;
        sh_mode = 2'd1; lv_mode = 2'd1;
        sh_solid = 24'h0; lv_solid = 24'h0;
        n_de = 0; n_hs = 0; n_vs = 0;
        fs_seen = 1'b0;
        sb_q.delete();
    endtask

    // One pixel period: optional write (early = before the divider edge, late = on the pix_en edge).
    task automatic step_pix(input bit wr, input bit late, input logic [31:0] a, input logic [31:0] d);
        sb_t e;
        obs_t got;
        if (wr && !late) begin
            bridge_addr = a; bridge_wr_data = d; bridge_wr = 1'b1;
        end
        @(posedge clk); #1;
        bridge_wr = 1'b0;
        if (wr && !late) model_write(a, d);
        expect_eq("fs_width", 64'(frame_start), 64'd0);
        if (wr && late) begin
            bridge_addr = a; bridge_wr_data = d; bridge_wr = 1'b1;
        end
        if (m_h == 0 && m_v == 0) begin
            lv_en = sh_en; lv_mode = sh_mode; lv_solid = sh_solid; fr_en = sh_en;
        end
        e.o = model_pix(m_h, m_v, lv_en, lv_mode, lv_solid);
        e.mode = lv_mode;
        sb_q.push_back(e);
        if (wr && late) model_write(a, d);
        if (m_h == HT - 1) begin
            m_h = 0;
            m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end else begin
            m_h = m_h + 1;
        end
        @(posedge clk); #1;
        bridge_wr = 1'b0;
        got = dut_obs();
        e = sb_q.pop_front();
        expect_eq("pixel", 64'(got), 64'(e.o));
        if (!e.o.de) expect_eq("blank_rgb", 64'(got.rgb), 64'd0);
        if (e.o.de && e.mode == 2'd1 && e.o.x == 10'd0 && e.o.y == 10'd0)
            expect_eq("bars_0_0", 64'(got.rgb), 64'hFFFFFF);
        if (e.o.de && e.mode == 2'd1 && e.o.x == 10'd2 && e.o.y == 10'd0)
            expect_eq("bars_2_0", 64'(got.rgb), 64'hFFFF00);
        if (e.o.de && e.mode == 2'd1 && e.o.x == 10'd18 && e.o.y == 10'd9)
            expect_eq("bars_rem", 64'(got.rgb), 64'h000000);
        if (e.o.de && e.mode == 2'd2 && e.o.x == 10'd8 && e.o.y == 10'd0)
            expect_eq("chk_8_0", 64'(got.rgb), 64'hFFFFFF);
        if (e.o.de && e.mode == 2'd2 && e.o.x == 10'd8 && e.o.y == 10'd8)
            expect_eq("chk_8_8", 64'(got.rgb), 64'h000000);
        if (e.o.de && e.mode == 2'd3 && e.o.x == 10'd12 && e.o.y == 10'd9)
            expect_eq("grad_12_9", 64'(got.rgb), 64'h0C0980);
        n_de += int'(got.de);
        n_hs += int'(got.hs);
        n_vs += int'(got.vs);
        if (got.fs) begin
            if (fs_seen) expect_eq("fs_period", 64'(cyc - last_fs), 64'(FRAME * CLKD));
            last_fs = cyc;
            fs_seen = 1'b1;
        end
        if (e.o.fs) begin
            expect_eq("frame_de", 64'(n_de), fr_en ? 64'(HA * VA) : 64'd0);
            expect_eq("frame_hs", 64'(n_hs), fr_en ? 64'(VT) : 64'd0);
            expect_eq("frame_vs", 64'(n_vs), fr_en ? 64'd1 : 64'd0);
            n_de = 0; n_hs = 0; n_vs = 0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step_pix(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        model_reset();
        #23;
        expect_eq("reset_state", 64'(dut_obs()), 64'd0);
        expect_eq("skip_tied", 64'(video_skip), 64'd0);
        @(negedge clk); reset_n = 1'b1;

        // Two default frames of colour bars.
        run(2 * FRAME);

        // Mid-frame switch to solid: rest of frame stays bars, next frame solid.
        run(5 * HT);
        step_pix(1'b1, 1'b0, BASE + 32'd4, 32'h0012_3456);
        step_pix(1'b1, 1'b0, BASE, 32'h0000_0001);
        step_pix(1'b1, 1'b0, BASE + 32'd8, 32'h0000_0007);
        run(FRAME - 5 * HT - 3);
        run(FRAME);

        // Disable, a blank frame, then re-enable from the frame boundary.
        run(10);
        step_pix(1'b1, 1'b0, BASE, 32'h0000_0000);
        run(FRAME - 11);
        run(2 * HT);
        step_pix(1'b1, 1'b0, BASE, 32'h0000_0001);
        run(FRAME - 2 * HT - 1);

        // Write on the boundary load edge lands one frame later (checker).
        step_pix(1'b1, 1'b1, BASE, 32'h0000_0005);
        run(FRAME - 1);
        run(FRAME);

        // Write just before the boundary load takes effect immediately (gradient).
        step_pix(1'b1, 1'b0, BASE, 32'h0000_0007);
        run(FRAME - 1);
        run(3 * HT + 5);

        // Asynchronous reset in the middle of an active line.
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        expect_eq("async_rst", 64'(dut_obs()), 64'd0);
        expect_eq("async_rst_u1", 64'({u1_rgb, u1_de, u1_hs, u1_vs, u1_fs, u1_x, u1_y}), 64'd0);
        @(negedge clk); @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        fork
            run(FRAME);
            begin
                for (int k = 0; k < 6; k++) begin
                    @(posedge clk); #1;
                    expect_eq("u1_pixel", 64'({u1_x, u1_rgb, u1_de}), 64'({10'(k), bar_ref(k / 2), 1'b1}));
                end
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
